// File: rtl/lfsr_seq_monitor.sv
// lfsr_seq_monitor: checker that sits behind the 4-bit feedback shift counter.
// It samples {Q3,Q2,Q1,Q0} on enabled clocks and predicts the next state with
// the counter's recurrence next = {Q0^Q1, Q3, Q2, Q1}. It reports lock,
// mismatches, zero-state lock-up and a sticky error.
// Optional build macro: LFSR_MON_PERIOD_EN adds sequence period measurement
// (period / period_vld). Without it both outputs are tied to zero.
module lfsr_seq_monitor #(
   parameter logic [3:0]  SEED      = 4'b1001,
   parameter int unsigned LOCK_RUN  = 4,
   parameter int unsigned ERR_LIMIT = 3,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic [3:0]       q,
   input  logic             resync,
   output logic             locked,
   output logic             err,
   output logic             lockup,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_cnt,
   output logic [4:0]       period,
   output logic             period_vld
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   localparam logic [3:0]       LOCK_RUN_C  = 4'(LOCK_RUN);
   localparam logic [3:0]       ERR_LIMIT_C = 4'(ERR_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

   // Counter recurrence: shift right by one, new MSB is Q0 xor Q1.
   function automatic logic [3:0] lfsr_next(input logic [3:0] s);
      return {s[0] ^ s[1], s[3], s[2], s[1]};
   endfunction

   state_t           state_r, state_nxt_s;
   logic [3:0]       pred_r, pred_nxt_s;
   logic [3:0]       run_r, run_nxt_s;
   logic [3:0]       miss_r, miss_nxt_s;
   logic [CNT_W-1:0] err_cnt_r, err_cnt_nxt_s;
   logic             lockup_r, lockup_nxt_s;
   logic             mismatch_r, mismatch_nxt_s;
   logic             locked_r, err_r;
   logic             match_s, zero_s;
   logic [3:0]       run_inc_s, miss_inc_s;

   assign match_s    = (q == pred_r);
   assign zero_s     = (q == 4'b0000);
   assign run_inc_s  = run_r + 4'd1;
   assign miss_inc_s = miss_r + 4'd1;

   // Next-state and next-output computation for the tracking FSM.
   always_comb begin
      state_nxt_s    = state_r;
      pred_nxt_s     = pred_r;
      run_nxt_s      = run_r;
      miss_nxt_s     = miss_r;
      err_cnt_nxt_s  = err_cnt_r;
      lockup_nxt_s   = lockup_r;
      mismatch_nxt_s = 1'b0;
      if (resync) begin
         // Restart wins over a coincident sample, which is discarded.
         state_nxt_s   = ST_IDLE;
         pred_nxt_s    = 4'b0000;
         run_nxt_s     = 4'd0;
         miss_nxt_s    = 4'd0;
         err_cnt_nxt_s = {CNT_W{1'b0}};
         lockup_nxt_s  = 1'b0;
      end else if (sample_en) begin
         case (state_r)
            ST_IDLE: begin
               pred_nxt_s  = lfsr_next(q);
               run_nxt_s   = 4'd0;
               state_nxt_s = ST_TRACK;
            end
            ST_TRACK: begin
               pred_nxt_s = lfsr_next(q);
               if (match_s) begin
                  run_nxt_s = run_inc_s;
                  if (run_inc_s == LOCK_RUN_C) begin
                     state_nxt_s = ST_LOCKED;
                     miss_nxt_s  = 4'd0;
                  end else begin
                     state_nxt_s = ST_TRACK;
                  end
               end else begin
                  run_nxt_s = 4'd0;
               end
            end
            ST_LOCKED: begin
               pred_nxt_s = lfsr_next(q);
               if (match_s) begin
                  miss_nxt_s = 4'd0;
               end else begin
                  mismatch_nxt_s = 1'b1;
                  miss_nxt_s     = miss_inc_s;
                  if (err_cnt_r != CNT_MAX) begin
                     err_cnt_nxt_s = err_cnt_r + CNT_W'(1);
                  end else begin
                     err_cnt_nxt_s = err_cnt_r;
                  end
                  if (miss_inc_s == ERR_LIMIT_C) begin
                     state_nxt_s = ST_ERROR;
                  end else begin
                     state_nxt_s = ST_LOCKED;
                  end
               end
            end
            ST_ERROR: begin
               // Absorbing: samples are ignored until resync or reset.
               state_nxt_s = ST_ERROR;
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
         // An all-zero sample means the counter is stuck; it overrides the
         // state transition but leaves the mismatch bookkeeping above intact.
         if (zero_s) begin
            lockup_nxt_s = 1'b1;
            state_nxt_s  = ST_ERROR;
         end else begin
            lockup_nxt_s = lockup_r;
         end
      end else begin
         mismatch_nxt_s = 1'b0;
      end
   end

   // State, prediction and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         pred_r     <= 4'b0000;
         run_r      <= 4'd0;
         miss_r     <= 4'd0;
         err_cnt_r  <= {CNT_W{1'b0}};
         lockup_r   <= 1'b0;
         mismatch_r <= 1'b0;
         locked_r   <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         pred_r     <= pred_nxt_s;
         run_r      <= run_nxt_s;
         miss_r     <= miss_nxt_s;
         err_cnt_r  <= err_cnt_nxt_s;
         lockup_r   <= lockup_nxt_s;
         mismatch_r <= mismatch_nxt_s;
         locked_r   <= (state_nxt_s == ST_LOCKED);
         err_r      <= (state_nxt_s == ST_ERROR);
      end
   end

   assign locked   = locked_r;
   assign err      = err_r;
   assign lockup   = lockup_r;
   assign mismatch = mismatch_r;
   assign err_cnt  = err_cnt_r;

`ifdef LFSR_MON_PERIOD_EN
   // pcnt_r == 0 means no SEED has been seen since entering LOCKED yet.
   logic [4:0] pcnt_r, pcnt_nxt_s;
   logic [4:0] period_r, period_nxt_s;
   logic       period_vld_r, period_vld_nxt_s;

   // Period counter: distance in samples between consecutive SEED values.
   always_comb begin
      pcnt_nxt_s       = pcnt_r;
      period_nxt_s     = period_r;
      period_vld_nxt_s = 1'b0;
      if (resync) begin
         pcnt_nxt_s = 5'd0;
      end else if (sample_en && (state_r == ST_LOCKED)) begin
         if (state_nxt_s != ST_LOCKED) begin
            pcnt_nxt_s = 5'd0;
         end else if (q == SEED) begin
            if (pcnt_r != 5'd0) begin
               period_nxt_s     = pcnt_r;
               period_vld_nxt_s = 1'b1;
            end else begin
               period_nxt_s = period_r;
            end
            pcnt_nxt_s = 5'd1;
         end else if ((pcnt_r != 5'd0) && (pcnt_r != 5'd31)) begin
            pcnt_nxt_s = pcnt_r + 5'd1;
         end else begin
            pcnt_nxt_s = pcnt_r;
         end
      end else if (state_r != ST_LOCKED) begin
         pcnt_nxt_s = 5'd0;
      end else begin
         pcnt_nxt_s = pcnt_r;
      end
   end

   // Period measurement registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt_r       <= 5'd0;
         period_r     <= 5'd0;
         period_vld_r <= 1'b0;
      end else begin
         pcnt_r       <= pcnt_nxt_s;
         period_r     <= period_nxt_s;
         period_vld_r <= period_vld_nxt_s;
      end
   end

   assign period     = period_r;
   assign period_vld = period_vld_r;
`else
   assign period     = 5'd0;
   assign period_vld = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_monitor.sv
// Testbench for lfsr_seq_monitor. Directed steps drive one sample per cycle;
// a behavioural model pushes the expected outputs into a scoreboard queue,
// which is popped and compared one cycle later. Honors LFSR_MON_PERIOD_EN.
module tb_lfsr_seq_monitor;

   localparam logic [3:0] SEED = 4'b1001;

   logic       clk;
   logic       rst;
   logic       sample_en;
   logic [3:0] q;
   logic       resync;
   logic       locked, err, lockup, mismatch, period_vld;
   logic [7:0] err_cnt;
   logic [4:0] period;

   typedef struct packed {
      logic       locked;
      logic       err;
      logic       lockup;
      logic       mismatch;
      logic [7:0] err_cnt;
      logic [4:0] period;
      logic       period_vld;
   } exp_t;

   exp_t sb_q[$];

   int errors = 0;
   int checks = 0;

   // model state: 0 idle, 1 track, 2 locked, 3 error
   int         m_st;
   logic [3:0] m_pred;
   int         m_run, m_miss, m_ecnt;
   logic       m_lock;
   logic       m_pstart;
   int         m_pcnt, m_period;

   lfsr_seq_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .sample_en  (sample_en),
      .q          (q),
      .resync     (resync),
      .locked     (locked),
      .err        (err),
      .lockup     (lockup),
      .mismatch   (mismatch),
      .err_cnt    (err_cnt),
      .period     (period),
      .period_vld (period_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] nxt(input logic [3:0] s);
      logic [3:0] r;
      r[3] = s[1] ^ s[0];
      r[2] = s[3];
      r[1] = s[2];
      r[0] = s[1];
      return r;
   endfunction

   function automatic logic [3:0] bad(input logic [3:0] p);
      logic [3:0] w;
      w = p ^ 4'b0001;
      if (w == 4'b0000) w = 4'b0010;
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_pred = 4'b0000; m_run = 0; m_miss = 0; m_ecnt = 0;
      m_lock = 1'b0; m_pstart = 1'b0; m_pcnt = 0; m_period = 0;
   endtask

   task automatic model_step(input logic se, input logic [3:0] qq, input logic rs);
      exp_t e;
      logic mis, vld;
      int   nst;
      mis = 1'b0;
      vld = 1'b0;
      if (rs) begin
         m_st = 0; m_run = 0; m_miss = 0; m_ecnt = 0; m_lock = 1'b0;
         m_pstart = 1'b0; m_pcnt = 0;
      end else if (se) begin
         nst = m_st;
         if (m_st == 0) begin
            m_run = 0;
            nst = 1;
         end else if (m_st == 1) begin
            if (qq == m_pred) begin
               m_run++;
               if (m_run == 4) begin nst = 2; m_miss = 0; end
            end else m_run = 0;
         end else if (m_st == 2) begin
            if (qq == m_pred) m_miss = 0;
            else begin
               mis = 1'b1;
               if (m_ecnt < 255) m_ecnt++;
               m_miss++;
               if (m_miss == 3) nst = 3;
            end
         end
         if (m_st != 3) m_pred = nxt(qq);
         if (qq == 4'b0000) begin m_lock = 1'b1; nst = 3; end
         if (m_st == 2 && nst == 2) begin
            if (qq == SEED) begin
               if (m_pstart) begin vld = 1'b1; m_period = m_pcnt; end
               m_pstart = 1'b1;
               m_pcnt = 1;
            end else if (m_pstart && m_pcnt < 31) m_pcnt++;
         end else begin
            m_pstart = 1'b0; m_pcnt = 0;
         end
         m_st = nst;
      end
      e.locked   = (m_st == 2);
      e.err      = (m_st == 3);
      e.lockup   = m_lock;
      e.mismatch = mis;
      e.err_cnt  = 8'(m_ecnt);
`ifdef LFSR_MON_PERIOD_EN
      e.period     = 5'(m_period);
      e.period_vld = vld;
`else
      e.period     = 5'd0;
      e.period_vld = 1'b0;
`endif
      sb_q.push_back(e);
   endtask

   task automatic compare(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      check({tag, "_locked"},   32'(locked),     32'(e.locked));
      check({tag, "_err"},      32'(err),        32'(e.err));
      check({tag, "_lockup"},   32'(lockup),     32'(e.lockup));
      check({tag, "_mismatch"}, 32'(mismatch),   32'(e.mismatch));
      check({tag, "_err_cnt"},  32'(err_cnt),    32'(e.err_cnt));
      check({tag, "_period"},   32'(period),     32'(e.period));
      check({tag, "_pvld"},     32'(period_vld), 32'(e.period_vld));
   endtask

   task automatic step(input logic se, input logic [3:0] qq, input logic rs, input string tag);
      @(negedge clk);
      sample_en = se;
      q         = qq;
      resync    = rs;
      model_step(se, qq, rs);
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_locked"},   32'(locked),     32'd0);
      check({tag, "_err"},      32'(err),        32'd0);
      check({tag, "_lockup"},   32'(lockup),     32'd0);
      check({tag, "_mismatch"}, 32'(mismatch),   32'd0);
      check({tag, "_err_cnt"},  32'(err_cnt),    32'd0);
      check({tag, "_period"},   32'(period),     32'd0);
      check({tag, "_pvld"},     32'(period_vld), 32'd0);
   endtask

   initial begin
      logic [3:0] cur;
      logic [3:0] w;
      rst = 1'b0; sample_en = 1'b0; q = 4'b0000; resync = 1'b0;
      model_reset();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // clean sequence from SEED: lock after 5th sample, two SEED revisits
      cur = SEED;
      for (int i = 0; i < 50; i++) begin
         step(1'b1, cur, 1'b0, "clean");
         if (i == 3) check("pre_lock", 32'(locked), 32'd0);
         if (i == 4) check("lock_at_5", 32'(locked), 32'd1);
         cur = nxt(cur);
      end

      // single corrupted sample while locked
      step(1'b1, 4'b0101, 1'b0, "corrupt");
      check("corrupt_pulse", 32'(mismatch), 32'd1);
      cur = nxt(4'b0101);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, cur, 1'b0, "resume");
         cur = nxt(cur);
      end
      check("resume_locked", 32'(locked), 32'd1);

      // no sample_en: everything holds
      step(1'b0, 4'b0000, 1'b0, "hold");
      step(1'b0, 4'b1111, 1'b0, "hold");

      // resync without sample, relock, then three consecutive misses
      step(1'b0, cur, 1'b1, "resync0");
      for (int i = 0; i < 6; i++) begin
         step(1'b1, cur, 1'b0, "relock");
         cur = nxt(cur);
      end
      for (int i = 0; i < 3; i++) begin
         w = bad(m_pred);
         step(1'b1, w, 1'b0, "miss");
         cur = nxt(w);
      end
      check("err_after_3", 32'(err), 32'd1);
      check("err_cnt_3", 32'(err_cnt), 32'd3);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, bad(cur), 1'b0, "frozen");
         cur = nxt(cur);
      end

      // resync with coincident sample: sample discarded
      step(1'b1, 4'b0000, 1'b1, "resync1");

      // zero lock-up in TRACK
      step(1'b1, SEED, 1'b0, "trk");
      step(1'b1, nxt(SEED), 1'b0, "trk");
      step(1'b1, 4'b0000, 1'b0, "zero");
      check("zero_lockup", 32'(lockup), 32'd1);
      step(1'b1, SEED, 1'b1, "resync2");
      check("resync_err", 32'(err), 32'd0);

      // relock, then asynchronous reset between clock edges
      cur = SEED;
      for (int i = 0; i < 7; i++) begin
         step(1'b1, cur, 1'b0, "lock2");
         cur = nxt(cur);
      end
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      sample_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();

      // first sample after reset release is an IDLE sample
      cur = 4'b0110;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, cur, 1'b0, "post_rst");
         cur = nxt(cur);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
